// File: rtl/core_pkg.sv
// Shared opcode/funct/ALU encodings and the decoded control bundle for ID and EX.
// decode_ctrl() is the single place that maps an instruction to its control bits.
package core_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd1;
  localparam logic [5:0] OP_SW    = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd3;
  localparam logic [5:0] OP_ADDI  = 6'd8;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_MUL = 6'h18;
  localparam logic [5:0] FN_AND = 6'h24;

  localparam logic [5:0] ALU_NOP = 6'd0;
  localparam logic [5:0] ALU_ADD = 6'd1;
  localparam logic [5:0] ALU_SUB = 6'd2;
  localparam logic [5:0] ALU_MUL = 6'd3;
  localparam logic [5:0] ALU_AND = 6'd4;

  typedef struct packed {
    logic [5:0] alu_ctrl;
    logic [4:0] dest;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [5:0] opcode, input logic [5:0] funct,
                                        input logic [4:0] rt, input logic [4:0] rd);
    ctrl_t c;
    c = '0;
    case (opcode)
      OP_RTYPE: begin
        c.dest      = rd;
        c.reg_write = 1'b1;
        case (funct)
          FN_ADD:  c.alu_ctrl = ALU_ADD;
          FN_SUB:  c.alu_ctrl = ALU_SUB;
          FN_MUL:  c.alu_ctrl = ALU_MUL;
          FN_AND:  c.alu_ctrl = ALU_AND;
          // unknown funct becomes an add whose result is never written
          default: begin
            c.alu_ctrl  = ALU_ADD;
            c.reg_write = 1'b0;
          end
        endcase
      end
      OP_LW: begin
        c.dest      = rt;
        c.reg_write = 1'b1;
        c.mem_read  = 1'b1;
      end
      OP_SW:   c.mem_write = 1'b1;
      OP_ADDI: begin
        c.dest      = rt;
        c.reg_write = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// IF/ID + writeback inputs and ID/EX outputs of the decode stage.
// master = pipeline environment driving the stage, slave = decode_stage itself.
interface decode_stage_if #(
  parameter int DATA_W = 32
);
  logic [31:0]       instr;
  logic              instr_valid;
  logic              stall;
  logic              flush;
  logic              wb_en;
  logic [4:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;

  logic [5:0]        opcode;
  logic [5:0]        ALU_control;
  logic [DATA_W-1:0] rsValue;
  logic [DATA_W-1:0] rtValue;
  logic [4:0]        shamt;
  logic [15:0]       immediate;
  logic [4:0]        dest_reg;
  logic              RegWrite;
  logic              MemRead;
  logic              MemWrite;
  logic              ex_valid;

  modport master (
    output instr, instr_valid, stall, flush, wb_en, wb_addr, wb_data,
    input  opcode, ALU_control, rsValue, rtValue, shamt, immediate, dest_reg,
           RegWrite, MemRead, MemWrite, ex_valid
  );

  modport slave (
    input  instr, instr_valid, stall, flush, wb_en, wb_addr, wb_data,
    output opcode, ALU_control, rsValue, rtValue, shamt, immediate, dest_reg,
           RegWrite, MemRead, MemWrite, ex_valid
  );
endinterface

// File: rtl/decode_stage_reg_file.sv
// reg_file: NREGS x DATA_W, two async read ports, one sync write port, r0 reads zero.
// REG_BYPASS_EN forwards a same-cycle write to the read ports.
module reg_file #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     ra_addr_i,
  output logic [DATA_W-1:0] ra_data_o,
  input  logic [AW-1:0]     rb_addr_i,
  output logic [DATA_W-1:0] rb_data_o,
  input  logic              we_i,
  input  logic [AW-1:0]     wa_addr_i,
  input  logic [DATA_W-1:0] wd_data_i
);
  logic [DATA_W-1:0] regs_q [NREGS];
  logic              wr_ok;

  assign wr_ok = we_i && (wa_addr_i != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wr_ok) begin
      regs_q[wa_addr_i] <= wd_data_i;
    end
  end

  always_comb begin
    ra_data_o = (ra_addr_i == '0) ? '0 : regs_q[ra_addr_i];
    rb_data_o = (rb_addr_i == '0) ? '0 : regs_q[rb_addr_i];
`ifdef REG_BYPASS_EN
    if (wr_ok && (wa_addr_i == ra_addr_i)) ra_data_o = wd_data_i;
    if (wr_ok && (wa_addr_i == rb_addr_i)) rb_data_o = wd_data_i;
`endif
  end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: field split, RF read, ALU/control decode and ID/EX register; 1-cycle latency.
// flush loads a bubble (beats stall), stall holds outputs while RF writes continue; REG_BYPASS_EN optional.
module decode_stage
  import core_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
) (
  input logic           clk,
  input logic           rst_n,
  decode_stage_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  logic [AW-1:0]     rs_idx, rt_idx, wb_idx;
  logic [DATA_W-1:0] rs_val, rt_val;
  ctrl_t             ctrl_dec;

  ctrl_t             ctrl_d, ctrl_q;
  logic [5:0]        opcode_d, opcode_q;
  logic [DATA_W-1:0] rs_val_d, rs_val_q, rt_val_d, rt_val_q;
  logic [4:0]        shamt_d, shamt_q;
  logic [15:0]       imm_d, imm_q;
  logic              valid_d, valid_q;

  assign rs_idx = AW'(bus.instr[25:21]);
  assign rt_idx = AW'(bus.instr[20:16]);
  assign wb_idx = AW'(bus.wb_addr);

  reg_file #(.DATA_W(DATA_W), .NREGS(NREGS)) u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .ra_addr_i (rs_idx),
    .ra_data_o (rs_val),
    .rb_addr_i (rt_idx),
    .rb_data_o (rt_val),
    .we_i      (bus.wb_en),
    .wa_addr_i (wb_idx),
    .wd_data_i (bus.wb_data)
  );

  assign ctrl_dec = decode_ctrl(bus.instr[31:26], bus.instr[5:0],
                                bus.instr[20:16], bus.instr[15:11]);

  always_comb begin
    ctrl_d   = ctrl_q;
    opcode_d = opcode_q;
    rs_val_d = rs_val_q;
    rt_val_d = rt_val_q;
    shamt_d  = shamt_q;
    imm_d    = imm_q;
    valid_d  = valid_q;
    if (bus.flush || (!bus.stall && !bus.instr_valid)) begin
      ctrl_d   = '0;
      opcode_d = '0;
      rs_val_d = '0;
      rt_val_d = '0;
      shamt_d  = '0;
      imm_d    = '0;
      valid_d  = 1'b0;
    end else if (!bus.stall) begin
      ctrl_d   = ctrl_dec;
      opcode_d = bus.instr[31:26];
      rs_val_d = rs_val;
      rt_val_d = rt_val;
      shamt_d  = bus.instr[10:6];
      imm_d    = bus.instr[15:0];
      valid_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q   <= '0;
      opcode_q <= '0;
      rs_val_q <= '0;
      rt_val_q <= '0;
      shamt_q  <= '0;
      imm_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      opcode_q <= opcode_d;
      rs_val_q <= rs_val_d;
      rt_val_q <= rt_val_d;
      shamt_q  <= shamt_d;
      imm_q    <= imm_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.opcode      = opcode_q;
  assign bus.ALU_control = ctrl_q.alu_ctrl;
  assign bus.rsValue     = rs_val_q;
  assign bus.rtValue     = rt_val_q;
  assign bus.shamt       = shamt_q;
  assign bus.immediate   = imm_q;
  assign bus.dest_reg    = ctrl_q.dest;
  assign bus.RegWrite    = ctrl_q.reg_write;
  assign bus.MemRead     = ctrl_q.mem_read;
  assign bus.MemWrite    = ctrl_q.mem_write;
  assign bus.ex_valid    = valid_q;
endmodule
